// File: rtl/feeder_pkg.sv
// Shared types and constants for the datapath input feeder.
package feeder_pkg;

  localparam int unsigned DATA_W = 64;

  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } feeder_state_t;

endpackage

// File: rtl/datapath_input_feeder_if.sv
// Upstream ready/valid bus plus the pulsed issue pair toward the negator datapath.
interface datapath_input_feeder_if #(
  parameter int unsigned DATA_W = feeder_pkg::DATA_W
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              output_valid;
  logic [DATA_W-1:0] output_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  output_valid,
    input  output_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output output_valid,
    output output_data
  );

endinterface

// File: rtl/feeder_fifo.sv
// Power-of-two circular buffer; push is ignored when full, pop when empty.
module feeder_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         word_t = feeder_pkg::word_t
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  word_t                  din,
  input  logic                   pop,
  output word_t                  head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  word_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr_q];
  assign count   = count_q;

  // Storage is not reset; occupancy tracking alone defines validity.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/datapath_input_feeder.sv
// Buffers upstream words and issues them as single-cycle pulses spaced ISSUE_GAP apart.
// Optional FEEDER_STATS_EN adds a saturating issued_count output.
module datapath_input_feeder
  import feeder_pkg::*;
#(
  parameter int unsigned DATA_W    = feeder_pkg::DATA_W,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ISSUE_GAP = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  datapath_input_feeder_if.slave bus,
  output logic [$clog2(DEPTH):0] fill_level
`ifdef FEEDER_STATS_EN
  ,
  output logic [31:0]            issued_count
`endif
);

  localparam int unsigned GAP_W = $clog2(ISSUE_GAP + 1);

  typedef logic [DATA_W-1:0] data_t;

  feeder_state_t    state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             ovalid_q, ovalid_d;
  data_t            odata_q, odata_d;
  logic             pop;
  logic             full;
  logic             empty;
  data_t            head;
  logic             issue;

  feeder_fifo #(
    .DEPTH  (DEPTH),
    .word_t (data_t)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (bus.in_valid),
    .din   (bus.in_data),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (fill_level)
  );

  assign bus.in_ready     = !full;
  assign bus.output_valid = ovalid_q;
  assign bus.output_data  = odata_q;
  assign issue            = (state_q == IDLE) && !empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      gap_q    <= '0;
      ovalid_q <= 1'b0;
      odata_q  <= '0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      ovalid_q <= ovalid_d;
      odata_q  <= odata_d;
    end
  end

  // Next state: HOLD lasts until the gap counter steps down to zero.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          gap_d   = GAP_W'(ISSUE_GAP - 1);
          state_d = (ISSUE_GAP > 1) ? HOLD : IDLE;
        end
      end
      HOLD: begin
        if (gap_q != '0) gap_d = gap_q - GAP_W'(1);
        if (gap_q <= GAP_W'(1)) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gap_d   = '0;
      end
    endcase
  end

  // Outputs: pop the head and register it as a one-cycle pulse.
  always_comb begin
    pop      = 1'b0;
    ovalid_d = 1'b0;
    odata_d  = odata_q;
    if (issue) begin
      pop      = 1'b1;
      ovalid_d = 1'b1;
      odata_d  = head;
    end
  end

`ifdef FEEDER_STATS_EN
  logic [31:0] issued_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      issued_cnt_q <= '0;
    end else if (issue && (issued_cnt_q != 32'hFFFF_FFFF)) begin
      issued_cnt_q <= issued_cnt_q + 32'd1;
    end
  end

  assign issued_count = issued_cnt_q;
`endif

endmodule
